// File: rtl/x9_seq_pkg.sv
// x9_seq_pkg: shared types and constants for the X9 run sequencer.
//   seq_state_t : sequencer FSM states
//   HOLD_CYC    : cycles the core is held in reset after loading
//   DEF_*       : default address / data / cycle-counter widths
package x9_seq_pkg;

  localparam int unsigned DEF_AW   = 8;
  localparam int unsigned DEF_W    = 8;
  localparam int unsigned DEF_CW   = 16;
  localparam int unsigned HOLD_CYC = 2;
  localparam int unsigned HOLD_CW  = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_HOLD = 3'd2,
    ST_RUN  = 3'd3,
    ST_READ = 3'd4,
    ST_FIN  = 3'd5
  } seq_state_t;

endpackage

// File: rtl/x9_run_sequencer_if.sv
// x9_run_sequencer_if: load and readback streams of the X9 run sequencer.
//   ld_valid/ld_ready/ld_addr/ld_data/ld_last : host -> sequencer load beats
//   rb_valid/rb_ready/rb_addr/rb_data         : sequencer -> host readback beats
//   master : host side, slave : sequencer side
interface x9_run_sequencer_if #(
  parameter int unsigned AW = x9_seq_pkg::DEF_AW,
  parameter int unsigned W  = x9_seq_pkg::DEF_W
) ();

  logic          ld_valid;
  logic          ld_ready;
  logic [AW-1:0] ld_addr;
  logic [W-1:0]  ld_data;
  logic          ld_last;

  logic          rb_valid;
  logic          rb_ready;
  logic [AW-1:0] rb_addr;
  logic [W-1:0]  rb_data;

  modport master (
    output ld_valid, ld_addr, ld_data, ld_last, rb_ready,
    input  ld_ready, rb_valid, rb_addr, rb_data
  );

  modport slave (
    input  ld_valid, ld_addr, ld_data, ld_last, rb_ready,
    output ld_ready, rb_valid, rb_addr, rb_data
  );

endinterface

// File: rtl/beat_counter.sv
// beat_counter: loadable up-counter with terminal-count compare.
//   clk, reset : clock, synchronous active-high reset
//   clr_i      : force count to zero (wins over en_i)
//   en_i       : increment by one
//   term_i     : terminal value; tc_o is high while cnt_o == term_i
//   cnt_o      : current count
module beat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] term_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             tc_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == term_i);

endmodule

// File: rtl/x9_run_sequencer.sv
// x9_run_sequencer: host-side initiator for the X9 core. Preloads data memory
// from the load stream, releases the core from reset, runs it until done or
// timeout, then streams a window of data memory back out.
//   clk, reset          : clock, synchronous active-high reset
//   start               : job command, accepted only in IDLE
//   rb_base, rb_count   : readback window, latched on accepted start
//   bus (slave)         : load and readback streams
//   core_reset/req/done : X9 core control
//   mem_*               : sequencer side of the data-memory port (mem_sel steers the mux)
//   busy, finished      : status; finished pulses for one cycle in FIN
//   timeout, cycles     : sticky timeout flag and run-cycle count of the last job
module x9_run_sequencer
  import x9_seq_pkg::*;
#(
  parameter int unsigned AW      = DEF_AW,
  parameter int unsigned W       = DEF_W,
  parameter int unsigned CW      = DEF_CW,
  parameter int unsigned MAX_CYC = 4000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] rb_base,
  input  logic [AW:0]   rb_count,
  x9_run_sequencer_if.slave bus,
  output logic          core_reset,
  output logic          core_req,
  input  logic          core_done,
  output logic          mem_sel,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [W-1:0]  mem_dat_out,
  input  logic [W-1:0]  mem_dat_in,
  output logic          busy,
  output logic          finished,
  output logic          timeout,
  output logic [CW-1:0] cycles
);

  localparam int unsigned NW = AW + 1;

  seq_state_t    state_q;
  logic [AW-1:0] rb_base_q;
  logic [NW-1:0] rb_count_q;
  logic          timeout_q;

  logic               in_idle, in_load, in_hold, in_run, in_read;
  logic               start_acc, ld_fire, rb_fire, rb_empty;
  logic               hold_tc, cyc_tc, rd_tc;
  logic [HOLD_CW-1:0] hold_cnt;
  logic [NW-1:0]      rd_idx;
  logic [AW-1:0]      rd_addr;

  assign in_idle = (state_q == ST_IDLE);
  assign in_load = (state_q == ST_LOAD);
  assign in_hold = (state_q == ST_HOLD);
  assign in_run  = (state_q == ST_RUN);
  assign in_read = (state_q == ST_READ);

  assign start_acc = in_idle && start;
  assign ld_fire   = in_load && bus.ld_valid;
  assign rb_empty  = (rb_count_q == '0);
  assign rb_fire   = bus.rb_valid && bus.rb_ready;

  // Hold count value only matters through its terminal compare.
  logic unused_hold_cnt;
  assign unused_hold_cnt = ^hold_cnt;

  // Core reset hold: counts HOLD cycles, cleared outside HOLD.
  beat_counter #(.WIDTH(HOLD_CW)) u_hold_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (!in_hold),
    .en_i   (in_hold),
    .term_i (HOLD_CW'(HOLD_CYC - 1)),
    .cnt_o  (hold_cnt),
    .tc_o   (hold_tc)
  );

  // Run-cycle count; terminal one below the limit so the limit edge is counted.
  beat_counter #(.WIDTH(CW)) u_cyc_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (start_acc),
    .en_i   (in_run),
    .term_i (CW'(MAX_CYC - 1)),
    .cnt_o  (cycles),
    .tc_o   (cyc_tc)
  );

  // Readback index; terminal is the last beat of the window.
  beat_counter #(.WIDTH(NW)) u_rd_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (!in_read),
    .en_i   (rb_fire),
    .term_i (rb_count_q - NW'(1)),
    .cnt_o  (rd_idx),
    .tc_o   (rd_tc)
  );

  // Window address wraps modulo 2^AW.
  assign rd_addr = rb_base_q + rd_idx[AW-1:0];

  // Sequencer FSM and job registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rb_base_q  <= '0;
      rb_count_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            rb_base_q  <= rb_base;
            rb_count_q <= rb_count;
            timeout_q  <= 1'b0;
            state_q    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (ld_fire && bus.ld_last) state_q <= ST_HOLD;
        end
        ST_HOLD: begin
          if (hold_tc) state_q <= ST_RUN;
        end
        ST_RUN: begin
          // done wins over the cycle limit on the same edge
          if (core_done) begin
            state_q <= ST_READ;
          end else if (cyc_tc) begin
            timeout_q <= 1'b1;
            state_q   <= ST_FIN;
          end
        end
        ST_READ: begin
          if (rb_empty || (rb_fire && rd_tc)) state_q <= ST_FIN;
        end
        ST_FIN:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Stream side: decoded from the state register; readback data is memory read-through.
  assign bus.ld_ready = in_load;
  assign bus.rb_valid = in_read && !rb_empty;
  assign bus.rb_addr  = rd_addr;
  assign bus.rb_data  = mem_dat_in;

  // Memory port: load beats write on their accepting edge, never under reset.
  always_comb begin
    mem_wr_en   = 1'b0;
    mem_addr    = '0;
    mem_dat_out = '0;
    if (in_load) begin
      mem_wr_en   = ld_fire && !reset;
      mem_addr    = bus.ld_addr;
      mem_dat_out = bus.ld_data;
    end else if (in_read) begin
      mem_addr = rd_addr;
    end
  end

  assign core_reset = !in_run;
  assign core_req   = in_run;
  assign mem_sel    = !in_run;
  assign busy       = !in_idle;
  assign finished   = (state_q == ST_FIN);
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_x9_run_sequencer.sv
// tb_x9_run_sequencer: scoreboard bench for x9_run_sequencer with a memory
// model, a core model that raises done after a set number of RUN cycles, and
// a reference copy of memory contents used to predict readback beats.
module tb_x9_run_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  rb_base;
  logic [8:0]  rb_count;
  logic        core_reset, core_req, core_done;
  logic        mem_sel, mem_wr_en;
  logic [7:0]  mem_addr, mem_dat_out, mem_dat_in;
  logic        busy, finished, timeout;
  logic [15:0] cycles;

  x9_run_sequencer_if #(.AW(8), .W(8)) bus ();

  x9_run_sequencer #(.AW(8), .W(8), .CW(16), .MAX_CYC(20)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .rb_base     (rb_base),
    .rb_count    (rb_count),
    .bus         (bus),
    .core_reset  (core_reset),
    .core_req    (core_req),
    .core_done   (core_done),
    .mem_sel     (mem_sel),
    .mem_wr_en   (mem_wr_en),
    .mem_addr    (mem_addr),
    .mem_dat_out (mem_dat_out),
    .mem_dat_in  (mem_dat_in),
    .busy        (busy),
    .finished    (finished),
    .timeout     (timeout),
    .cycles      (cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory behind the core/sequencer mux; the core model never writes it.
  logic [7:0] mem [0:255];
  int         wr_count = 0;
  always @(posedge clk) begin
    if (mem_wr_en && mem_sel) begin
      mem[mem_addr] <= mem_dat_out;
      wr_count      <= wr_count + 1;
    end
  end
  assign mem_dat_in = mem[mem_addr];

  // Core model: done in RUN cycle number done_at (0 = never).
  int done_at = 0;
  int run_seen;
  always @(posedge clk) begin
    if (reset || !core_req) run_seen <= 0;
    else                    run_seen <= run_seen + 1;
  end
  always_comb core_done = core_req && (done_at > 0) && (run_seen == done_at - 1);

  // Scoreboard state.
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] model [0:255];
  logic [7:0] ld_a[$], ld_d[$];
  logic [7:0] exp_a[$], exp_d[$];
  logic [7:0] obs_a[$], obs_d[$];
  int n_fin, n_valid_cyc, n_unstable, idx_rst_low, idx_done, idx_valid;
  bit timed_out, end_busy, load_ok;

  task automatic push_load(input logic [7:0] a, input logic [7:0] d);
    ld_a.push_back(a);
    ld_d.push_back(d);
    model[a] = d;
  endtask

  task automatic push_window(input logic [7:0] base, input int cnt);
    logic [7:0] a;
    for (int i = 0; i < cnt; i++) begin
      a = base + 8'(i);
      exp_a.push_back(a);
      exp_d.push_back(model[a]);
    end
  endtask

  task automatic cmd_start(input logic [7:0] base, input logic [8:0] cnt);
    @(negedge clk);
    start = 1'b1; rb_base = base; rb_count = cnt;
    @(negedge clk);
    start = 1'b0; rb_base = ~base; rb_count = ~cnt;
    #1;
  endtask

  // Drive queued load beats; returns right before the last beat's edge.
  task automatic load_beats(input int budget, output bit ok);
    int i = 0;
    int k = 0;
    while (i < ld_a.size() && k < budget) begin
      @(negedge clk);
      bus.ld_valid = 1'b1;
      bus.ld_addr  = ld_a[i];
      bus.ld_data  = ld_d[i];
      bus.ld_last  = (i == ld_a.size() - 1);
      #1;
      if (bus.ld_ready) i++;
      k++;
    end
    ok = (i == ld_a.size());
    ld_a.delete();
    ld_d.delete();
  endtask

  // Run through HOLD/RUN/READ/FIN recording beats and timing until one cycle after finished.
  task automatic collect(input int mode, input int budget);
    bit         prev_stall = 1'b0;
    bit         fin_seen = 1'b0;
    logic [7:0] prev_a = '0, prev_d = '0;
    obs_a.delete(); obs_d.delete();
    n_fin = 0; n_valid_cyc = 0; n_unstable = 0;
    idx_rst_low = -1; idx_done = -1; idx_valid = -1;
    timed_out = 1'b1; end_busy = 1'b1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      bus.ld_valid = 1'b0;
      bus.ld_last  = 1'b0;
      bus.rb_ready = (mode == 0) ? 1'b1 : ((k % 3) == 0);
      #1;
      if (!core_reset && idx_rst_low < 0) idx_rst_low = k;
      if (core_done && idx_done < 0) idx_done = k;
      if (prev_stall && !(bus.rb_valid && bus.rb_addr == prev_a && bus.rb_data == prev_d))
        n_unstable++;
      if (bus.rb_valid) begin
        n_valid_cyc++;
        if (idx_valid < 0) idx_valid = k;
        if (bus.rb_ready) begin
          obs_a.push_back(bus.rb_addr);
          obs_d.push_back(bus.rb_data);
        end
      end
      prev_stall = bus.rb_valid && !bus.rb_ready;
      prev_a = bus.rb_addr;
      prev_d = bus.rb_data;
      if (finished) n_fin++;
      if (fin_seen) begin
        end_busy  = busy;
        timed_out = 1'b0;
        break;
      end
      if (finished) fin_seen = 1'b1;
    end
    bus.rb_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({core_reset, mem_sel, busy, finished, timeout, bus.ld_ready, bus.rb_valid, core_req, mem_wr_en} !== 9'b110000000) begin
      n_err++;
      $display("FAIL reset_flags: got %b want %b", {core_reset, mem_sel, busy, finished, timeout,
               bus.ld_ready, bus.rb_valid, core_req, mem_wr_en}, 9'b110000000);
    end
    n_cmp++;
    if (cycles !== 16'd0) begin n_err++; $display("FAIL reset_cycles: got %0d want 0", cycles); end
  endtask

  task automatic test_normal;
    logic [7:0] ea, ed, oa, od;
    push_load(8'h00, 8'h05); push_load(8'h01, 8'h0A); push_load(8'h02, 8'h0F);
    push_window(8'h00, 3);
    done_at = 10;
    cmd_start(8'h00, 9'd3);
    n_cmp++;
    if (bus.ld_ready !== 1'b1 || busy !== 1'b1) begin
      n_err++; $display("FAIL normal_ld_ready: got ready=%b busy=%b want 1 1", bus.ld_ready, busy);
    end
    load_beats(20, load_ok);
    collect(0, 100);
    n_cmp++;
    if (!load_ok || timed_out) begin n_err++; $display("FAIL normal_progress: load_ok=%b timed_out=%b want 1 0", load_ok, timed_out); end
    n_cmp++;
    if (obs_a.size() != exp_a.size()) begin n_err++; $display("FAIL normal_beat_count: got %0d want %0d", obs_a.size(), exp_a.size()); end
    while (exp_a.size() > 0) begin
      ea = exp_a.pop_front(); ed = exp_d.pop_front();
      n_cmp++;
      if (obs_a.size() == 0) begin n_err++; $display("FAIL normal_beat: missing beat want %h:%h", ea, ed); end
      else begin
        oa = obs_a.pop_front(); od = obs_d.pop_front();
        if ({oa, od} !== {ea, ed}) begin n_err++; $display("FAIL normal_beat: got %h:%h want %h:%h", oa, od, ea, ed); end
      end
    end
    n_cmp++;
    if (cycles !== 16'd10) begin n_err++; $display("FAIL normal_cycles: got %0d want 10", cycles); end
    n_cmp++;
    if (n_fin != 1 || timeout !== 1'b0 || end_busy !== 1'b0) begin
      n_err++; $display("FAIL normal_status: fin=%0d timeout=%b busy=%b want 1 0 0", n_fin, timeout, end_busy);
    end
    n_cmp++;
    if (idx_rst_low != 2) begin n_err++; $display("FAIL normal_hold_len: got %0d want 2", idx_rst_low); end
    n_cmp++;
    if (idx_valid - idx_done != 1) begin n_err++; $display("FAIL normal_first_valid: got %0d want 1", idx_valid - idx_done); end
  endtask

  task automatic test_backpressure;
    logic [7:0] ea, ed, oa, od;
    for (int i = 0; i < 5; i++) push_load(8'h10 + 8'(i), 8'($urandom));
    push_window(8'h10, 5);
    done_at = 3;
    cmd_start(8'h10, 9'd5);
    load_beats(20, load_ok);
    collect(1, 100);
    n_cmp++;
    if (!load_ok || timed_out) begin n_err++; $display("FAIL bp_progress: load_ok=%b timed_out=%b want 1 0", load_ok, timed_out); end
    n_cmp++;
    if (obs_a.size() != exp_a.size()) begin n_err++; $display("FAIL bp_beat_count: got %0d want %0d", obs_a.size(), exp_a.size()); end
    while (exp_a.size() > 0) begin
      ea = exp_a.pop_front(); ed = exp_d.pop_front();
      n_cmp++;
      if (obs_a.size() == 0) begin n_err++; $display("FAIL bp_beat: missing beat want %h:%h", ea, ed); end
      else begin
        oa = obs_a.pop_front(); od = obs_d.pop_front();
        if ({oa, od} !== {ea, ed}) begin n_err++; $display("FAIL bp_beat: got %h:%h want %h:%h", oa, od, ea, ed); end
      end
    end
    n_cmp++;
    if (n_unstable != 0) begin n_err++; $display("FAIL bp_stable: got %0d unstable stalls want 0", n_unstable); end
    n_cmp++;
    if (cycles !== 16'd3 || n_fin != 1) begin n_err++; $display("FAIL bp_status: cycles=%0d fin=%0d want 3 1", cycles, n_fin); end
  endtask

  task automatic test_timeout;
    push_load(8'h20, 8'h5A);
    done_at = 0;
    cmd_start(8'h20, 9'd3);
    load_beats(20, load_ok);
    collect(0, 100);
    n_cmp++;
    if (!load_ok || timed_out) begin n_err++; $display("FAIL to_progress: load_ok=%b timed_out=%b want 1 0", load_ok, timed_out); end
    n_cmp++;
    if (timeout !== 1'b1) begin n_err++; $display("FAIL to_flag: got %b want 1", timeout); end
    n_cmp++;
    if (cycles !== 16'd20) begin n_err++; $display("FAIL to_cycles: got %0d want 20", cycles); end
    n_cmp++;
    if (n_valid_cyc != 0 || n_fin != 1 || end_busy !== 1'b0) begin
      n_err++; $display("FAIL to_status: valid=%0d fin=%0d busy=%b want 0 1 0", n_valid_cyc, n_fin, end_busy);
    end
  endtask

  task automatic test_wrap;
    logic [7:0] ea, ed, oa, od;
    push_load(8'hFF, 8'h11); push_load(8'hFE, 8'h22);
    push_load(8'hFF, 8'h33); push_load(8'h00, 8'h44);
    push_window(8'hFE, 3);
    done_at = 2;
    cmd_start(8'hFE, 9'd3);
    n_cmp++;
    if (timeout !== 1'b0) begin n_err++; $display("FAIL wrap_timeout_clr: got %b want 0", timeout); end
    load_beats(20, load_ok);
    collect(0, 100);
    n_cmp++;
    if (!load_ok || timed_out) begin n_err++; $display("FAIL wrap_progress: load_ok=%b timed_out=%b want 1 0", load_ok, timed_out); end
    n_cmp++;
    if (obs_a.size() != exp_a.size()) begin n_err++; $display("FAIL wrap_beat_count: got %0d want %0d", obs_a.size(), exp_a.size()); end
    while (exp_a.size() > 0) begin
      ea = exp_a.pop_front(); ed = exp_d.pop_front();
      n_cmp++;
      if (obs_a.size() == 0) begin n_err++; $display("FAIL wrap_beat: missing beat want %h:%h", ea, ed); end
      else begin
        oa = obs_a.pop_front(); od = obs_d.pop_front();
        if ({oa, od} !== {ea, ed}) begin n_err++; $display("FAIL wrap_beat: got %h:%h want %h:%h", oa, od, ea, ed); end
      end
    end
  endtask

  task automatic test_empty_window;
    push_load(8'h30, 8'h99);
    done_at = 1;
    cmd_start(8'h30, 9'd0);
    load_beats(20, load_ok);
    collect(0, 100);
    n_cmp++;
    if (!load_ok || timed_out) begin n_err++; $display("FAIL empty_progress: load_ok=%b timed_out=%b want 1 0", load_ok, timed_out); end
    n_cmp++;
    if (n_valid_cyc != 0 || n_fin != 1) begin n_err++; $display("FAIL empty_status: valid=%0d fin=%0d want 0 1", n_valid_cyc, n_fin); end
    n_cmp++;
    if (cycles !== 16'd1) begin n_err++; $display("FAIL empty_cycles: got %0d want 1", cycles); end
  endtask

  task automatic test_reset_mid_run;
    int  w0;
    bit  in_run = 1'b0;
    push_load(8'h40, 8'h11);
    done_at = 0;
    cmd_start(8'h40, 9'd1);
    load_beats(20, load_ok);
    for (int k = 0; k < 20 && !in_run; k++) begin
      @(negedge clk);
      bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
      #1;
      in_run = core_req;
    end
    n_cmp++;
    if (!in_run) begin n_err++; $display("FAIL rst_reach_run: got core_req=%b want 1", core_req); end
    // RUN cycle 2: stray start must be ignored
    @(negedge clk); start = 1'b1; rb_base = 8'h55; rb_count = 9'd4;
    @(negedge clk); start = 1'b0;
    #1;
    n_cmp++;
    if (core_req !== 1'b1 || cycles !== 16'd2) begin
      n_err++; $display("FAIL rst_start_ignored: core_req=%b cycles=%0d want 1 2", core_req, cycles);
    end
    @(negedge clk);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    #1;
    n_cmp++;
    if ({core_reset, busy, core_req, mem_sel} !== 4'b1001 || cycles !== 16'd0) begin
      n_err++; $display("FAIL rst_mid_run: rst/busy/req/sel=%b cycles=%0d want 1001 0",
                        {core_reset, busy, core_req, mem_sel}, cycles);
    end
    // Reset landing on a load beat must not write memory.
    cmd_start(8'h00, 9'd1);
    @(negedge clk);
    bus.ld_valid = 1'b1; bus.ld_addr = 8'h40; bus.ld_data = 8'h77; bus.ld_last = 1'b0;
    reset = 1'b1; w0 = wr_count;
    #1;
    n_cmp++;
    if (mem_wr_en !== 1'b0) begin n_err++; $display("FAIL rst_load_wr_en: got %b want 0", mem_wr_en); end
    @(negedge clk); reset = 1'b0; bus.ld_valid = 1'b0;
    #1;
    n_cmp++;
    if (wr_count != w0 || busy !== 1'b0 || mem[8'h40] !== model[8'h40]) begin
      n_err++; $display("FAIL rst_load_nowrite: writes=%0d busy=%b mem=%h want %0d 0 %h",
                        wr_count - w0, busy, mem[8'h40], 0, model[8'h40]);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; rb_base = '0; rb_count = '0;
    bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_data = '0; bus.ld_last = 1'b0;
    bus.rb_ready = 1'b0;
    test_reset();
    test_normal();
    test_backpressure();
    test_timeout();
    test_wrap();
    test_empty_window();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/x9_run_sequencer.md
# x9_run_sequencer

Host-side initiator for the X9 core. Preloads data memory over a valid/ready load stream, releases the core from reset, runs it until `done` or a cycle timeout, then streams a window of data memory back out. It owns the data-memory port whenever the core is not running, and it drives the core's `reset` and `req`.

## Interface
Parameters:
- `AW`, 8: data-memory address width.
- `W`, 8: data width.
- `CW`, 16: run-cycle counter width.
- `MAX_CYC`, 16'd4000: run timeout in cycles; must be ≥ 1.

Ports:
- `clk`  in  1  single clock; all state changes on posedge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle command; ignored unless in IDLE.
- `ld_valid`  in  1 / `ld_ready`  out  1  load-stream handshake.
- `ld_addr`  in  AW / `ld_data`  in  W / `ld_last`  in  1  load beat payload; `ld_last` marks the final beat.
- `rb_base`  in  AW / `rb_count`  in  AW+1  readback window, sampled on `start`.
- `rb_valid`  out  1 / `rb_ready`  in  1  readback handshake.
- `rb_addr`  out  AW / `rb_data`  out  W  readback beat payload.
- `core_reset`  out  1  drives the core's `reset`.
- `core_req`  out  1  run request to the core.
- `core_done`  in  1  core's `done`.
- `mem_sel`  out  1  1 = sequencer owns the data-memory port; 0 = core owns it.
- `mem_wr_en`  out  1 / `mem_addr`  out  AW / `mem_dat_out`  out  W  memory write/address port.
- `mem_dat_in`  in  W  combinational read data from data memory.
- `busy`  out  1  high in every state except IDLE.
- `finished`  out  1  one-cycle pulse in FIN.
- `timeout`  out  1  sticky; cleared on accepted `start`.
- `cycles`  out  CW  run-cycle count; held until the next accepted `start`.

## Operation
States: IDLE, LOAD, HOLD, RUN, READ, FIN.
- **IDLE:** `core_reset`=1, `mem_sel`=1. On `start`: latch `rb_base`/`rb_count`, clear `cycles` and `timeout`, go to LOAD.
- **LOAD:** `ld_ready`=1. Each beat with `ld_valid&&ld_ready` sets `mem_wr_en`=1, `mem_addr`=`ld_addr`, `mem_dat_out`=`ld_data` combinationally, so the write lands on that edge. A beat carrying `ld_last` is written, then the state goes to HOLD. A later beat to the same address overwrites the earlier one.
- **HOLD:** `core_reset`=1 for exactly 2 cycles, then go to RUN.
- **RUN:** `core_reset`=0, `core_req`=1, `mem_sel`=0, `mem_wr_en`=0. `cycles` increments every RUN cycle.
  - `core_done`=1 sampled on an edge: go to READ. That cycle is counted.
  - Otherwise, when `cycles` reaches `MAX_CYC`: set `timeout`=1 and go to FIN, with no readback.
  - If `core_done` and the limit occur on the same edge, `core_done` wins.
- **READ:** `core_reset`=1, `mem_sel`=1, index `i` starts at 0.
  - `rb_addr`=`mem_addr`=`rb_base`+`i` modulo 2^AW, so the window wraps past the top of memory.
  - `rb_data`=`mem_dat_in`, `rb_valid`=1.
  - `i` advances on `rb_valid&&rb_ready`. The beat with `i`=`rb_count`-1 goes to FIN.
  - `rb_count`=0 passes through READ for one cycle with `rb_valid`=0, then goes to FIN.
- **FIN:** `finished`=1 for one cycle, then go to IDLE.
- `rb_*` payload must stay stable while `rb_valid&&!rb_ready`.
- `ld_ready`, `rb_valid`, `mem_wr_en` and `core_req` are 0 in every state other than their own.

## Timing
- **Reset values:** state IDLE; `core_reset`=1, `mem_sel`=1; all other outputs 0, `cycles`=0.
- **Reset mid-operation:** IDLE on the next edge. No memory write occurs in the reset cycle.
- **`start` → `ld_ready`:** 1 cycle.
- **Last load beat → `core_reset` low:** 3 cycles (LOAD edge plus 2 HOLD cycles).
- **Readback:** one beat per cycle when `rb_ready` is held high. The first `rb_valid` appears in the cycle after the `core_done` edge.
- **`core_done`:** sampled only in RUN; ignored elsewhere.

## Structure
- Package `x9_seq_pkg`:
  - `seq_state_t` enum.
  - `HOLD_CYC`=2.
  - Default widths `AW`/`W`/`CW`.
- One sub-module, `beat_counter`: a loadable up-counter with terminal-count compare. It is used for the HOLD count, the RUN cycle count and the READ index.
- The memory-port mux between core and sequencer sits at the level above this block and is steered by `mem_sel`.

## Test plan
- **Normal run:** `start`, load 3 beats (addr 0→0x05, 1→0x0A, 2→0x0F with `ld_last`), core model asserts `done` after 10 RUN cycles, `rb_base`=0, `rb_count`=3 → `rb_data` 0x05, 0x0A, 0x0F; `cycles`=10; `finished` pulses once; `timeout`=0.
- **Backpressure:** `rb_ready` toggled 1,0,0,1,… → every beat is delivered exactly once and the payload is stable while stalled.
- **Timeout:** with `MAX_CYC`=20, `done` is never asserted → `timeout`=1, `cycles`=20, no `rb_valid`, back in IDLE after FIN.
- **Wrap and empty window:** `rb_base`=0xFE, `rb_count`=3 → addresses 0xFE, 0xFF, 0x00. Separately, `rb_count`=0 → no beats and a `finished` pulse.
- **Reset mid-run:** `reset` asserted in RUN cycle 5 → next cycle `core_reset`=1, `busy`=0, `cycles`=0. `start` pulses outside IDLE are ignored.
